// File: rtl/bcd_time_counter.sv
// MM:SS BCD time counter with run/hold/adjust modes.
// Separate prescalers pace the one-second tick and the manual adjust step.
module bcd_time_counter #(
  parameter int TICK_DIV  = 50000000,
  parameter int ADJ_DIV   = 25000000,
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] sec_one,
  output logic [3:0] sec_ten,
  output logic [3:0] min_one,
  output logic [3:0] min_ten,
  output logic       sec_tick,
  output logic       wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);
  localparam logic [3:0]    LIM_TEN   = 4'(MIN_LIMIT / 10);
  localparam logic [3:0]    LIM_ONE   = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_ADJ} state_e;

  state_e state_q, state_d;

  logic [TW-1:0] tick_psc_q, tick_psc_d, tick_cnt;
  logic [AW-1:0] adj_psc_q, adj_psc_d, adj_cnt;
  logic [3:0]    sec_one_q, sec_ten_q, min_one_q, min_ten_q;
  logic [3:0]    sec_one_d, sec_ten_d, min_one_d, min_ten_d;
  logic          sec_tick_q, sec_tick_d, wrap_q, wrap_d;
  logic          inc_sec, inc_min, sec_max, min_max;

  always_comb begin
    state_d = ST_RUN;
    if (adj)        state_d = ST_ADJ;
    else if (pause) state_d = ST_HOLD;
  end

  always_comb begin
    // Crossing the ADJ boundary restarts both prescalers from zero.
    tick_cnt   = (state_q == ST_ADJ) ? '0 : tick_psc_q;
    adj_cnt    = (state_q == ST_ADJ) ? adj_psc_q : '0;
    sec_max    = (sec_ten_q == 4'd5) && (sec_one_q == 4'd9);
    min_max    = (min_ten_q == LIM_TEN) && (min_one_q == LIM_ONE);
    tick_psc_d = tick_cnt;
    adj_psc_d  = '0;
    sec_tick_d = 1'b0;
    wrap_d     = 1'b0;
    inc_sec    = 1'b0;
    inc_min    = 1'b0;

    case (state_d)
      ST_RUN: begin
        if (tick_cnt == TICK_LAST) begin
          tick_psc_d = '0;
          inc_sec    = 1'b1;
          sec_tick_d = 1'b1;
          inc_min    = sec_max;
          wrap_d     = sec_max && min_max;
        end else begin
          tick_psc_d = tick_cnt + TW'(1);
        end
      end
      ST_ADJ: begin
        tick_psc_d = '0;
        if (adj_cnt == ADJ_LAST) begin
          adj_psc_d = '0;
          inc_min   = sel;
          inc_sec   = ~sel;
        end else begin
          adj_psc_d = adj_cnt + AW'(1);
        end
      end
      default: ;
    endcase

    sec_one_d = sec_one_q;
    sec_ten_d = sec_ten_q;
    min_one_d = min_one_q;
    min_ten_d = min_ten_q;

    if (inc_sec) begin
      if (sec_one_q == 4'd9) begin
        sec_one_d = 4'd0;
        sec_ten_d = (sec_ten_q == 4'd5) ? 4'd0 : sec_ten_q + 4'd1;
      end else begin
        sec_one_d = sec_one_q + 4'd1;
      end
    end

    if (inc_min) begin
      if (min_max) begin
        min_one_d = 4'd0;
        min_ten_d = 4'd0;
      end else if (min_one_q == 4'd9) begin
        min_one_d = 4'd0;
        min_ten_d = min_ten_q + 4'd1;
      end else begin
        min_one_d = min_one_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      tick_psc_q <= '0;
      adj_psc_q  <= '0;
      sec_one_q  <= 4'd0;
      sec_ten_q  <= 4'd0;
      min_one_q  <= 4'd0;
      min_ten_q  <= 4'd0;
      sec_tick_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_psc_q <= tick_psc_d;
      adj_psc_q  <= adj_psc_d;
      sec_one_q  <= sec_one_d;
      sec_ten_q  <= sec_ten_d;
      min_one_q  <= min_one_d;
      min_ten_q  <= min_ten_d;
      sec_tick_q <= sec_tick_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_one  = sec_one_q;
  assign sec_ten  = sec_ten_q;
  assign min_one  = min_one_q;
  assign min_ten  = min_ten_q;
  assign sec_tick = sec_tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: two instances (minute limits 12 and 59) on shared inputs,
// checked every cycle against a seconds/minutes arithmetic model plus a vector table.
module tb_bcd_time_counter;

  localparam int TD = 4;
  localparam int AD = 2;

  logic clk = 1'b0;
  logic reset, pause, adj, sel;
  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic a_tick, a_wrap, b_tick, b_wrap;

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(TD), .ADJ_DIV(AD), .MIN_LIMIT(12)) dut (
    .clk(clk), .reset(reset), .pause(pause), .adj(adj), .sel(sel),
    .sec_one(a_so), .sec_ten(a_st), .min_one(a_mo), .min_ten(a_mt),
    .sec_tick(a_tick), .wrap(a_wrap)
  );

  bcd_time_counter #(.TICK_DIV(TD), .ADJ_DIV(AD), .MIN_LIMIT(59)) dut59 (
    .clk(clk), .reset(reset), .pause(pause), .adj(adj), .sel(sel),
    .sec_one(b_so), .sec_ten(b_st), .min_one(b_mo), .min_ten(b_mt),
    .sec_tick(b_tick), .wrap(b_wrap)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer time, counters count 1..DIV.
  int m_sec[2], m_min[2], m_tc[2], m_ac[2];
  bit m_tick[2], m_wrap[2];
  int lim[2];

  typedef struct {
    bit r, p, a, s;
    int n;
    int es, em;
    bit et, ew;
  } vec_t;

  vec_t tbl[$];

  function automatic void model_step(int k);
    m_tick[k] = 1'b0;
    m_wrap[k] = 1'b0;
    if (reset) begin
      m_sec[k] = 0; m_min[k] = 0; m_tc[k] = 0; m_ac[k] = 0;
    end else if (adj) begin
      m_tc[k] = 0;
      m_ac[k]++;
      if (m_ac[k] == AD) begin
        m_ac[k] = 0;
        if (sel) m_min[k] = (m_min[k] == lim[k]) ? 0 : m_min[k] + 1;
        else     m_sec[k] = (m_sec[k] + 1) % 60;
      end
    end else begin
      m_ac[k] = 0;
      if (!pause) begin
        m_tc[k]++;
        if (m_tc[k] == TD) begin
          m_tc[k] = 0;
          m_tick[k] = 1'b1;
          if (m_sec[k] == 59) begin
            m_sec[k] = 0;
            if (m_min[k] == lim[k]) begin
              m_min[k] = 0;
              m_wrap[k] = 1'b1;
            end else begin
              m_min[k]++;
            end
          end else begin
            m_sec[k]++;
          end
        end
      end
    end
  endfunction

  function automatic logic [17:0] pack(int s, int m, bit t, bit w);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), t, w};
  endfunction

  task automatic check(string name, logic [17:0] got, logic [17:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got mm:ss=%h%h:%h%h tick=%b wrap=%b, want %h%h:%h%h tick=%b wrap=%b",
               name, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("model_lim12", {a_mt, a_mo, a_st, a_so, a_tick, a_wrap},
          pack(m_sec[0], m_min[0], m_tick[0], m_wrap[0]));
    check("model_lim59", {b_mt, b_mo, b_st, b_so, b_tick, b_wrap},
          pack(m_sec[1], m_min[1], m_tick[1], m_wrap[1]));
  endtask

  task automatic drive(bit r, bit p, bit a, bit s, int n);
    reset = r; pause = p; adj = a; sel = s;
    repeat (n) cyc();
  endtask

  initial begin
    lim[0] = 12;
    lim[1] = 59;
    for (int k = 0; k < 2; k++) begin
      m_sec[k] = 0; m_min[k] = 0; m_tc[k] = 0; m_ac[k] = 0;
      m_tick[k] = 0; m_wrap[k] = 0;
    end
    reset = 1'b1; pause = 1'b0; adj = 1'b0; sel = 1'b0;

    //                r  p  a  s   n   ss  mm  tk wr   (minute limit 12 instance)
    tbl.push_back('{1, 0, 0, 0,   2,  0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  40, 10,  0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   2, 10,  0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,  20, 10,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 10,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 11,  0, 1, 0});
    tbl.push_back('{0, 0, 1, 1,   2, 11,  1, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  22, 11, 12, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  96, 59, 12, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   3, 59, 12, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   1,  0,  0, 1, 1});
    tbl.push_back('{0, 0, 1, 1,  24,  0, 12, 0, 0});
    tbl.push_back('{0, 0, 1, 1,   2,  0,  0, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  10,  0,  5, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 116, 58,  5, 0, 0});
    tbl.push_back('{0, 0, 1, 0,   2, 59,  5, 0, 0});
    tbl.push_back('{0, 0, 1, 0,   2,  0,  5, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  74, 37,  5, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   3, 37,  5, 0, 0});
    tbl.push_back('{1, 0, 0, 0,   1,  0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   3,  0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   1,  1,  0, 1, 0});

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].p, tbl[i].a, tbl[i].s, tbl[i].n);
      check($sformatf("row%0d", i), {a_mt, a_mo, a_st, a_so, a_tick, a_wrap},
            pack(tbl[i].es, tbl[i].em, tbl[i].et, tbl[i].ew));
    end

    // 59:59 preload on the 59-limit instance, then one tick rolls to 00:00 with wrap.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 118);
    drive(0, 0, 1, 0, 118);
    check("preload_5959", {b_mt, b_mo, b_st, b_so, b_tick, b_wrap}, pack(59, 59, 0, 0));
    drive(0, 0, 0, 0, 3);
    check("pre_wrap_5959", {b_mt, b_mo, b_st, b_so, b_tick, b_wrap}, pack(59, 59, 0, 0));
    drive(0, 0, 0, 0, 1);
    check("wrap_5959", {b_mt, b_mo, b_st, b_so, b_tick, b_wrap}, pack(0, 0, 1, 1));

    // Pause together with adj: adjust wins.
    drive(0, 1, 1, 0, 2);
    check("adj_over_pause", {b_mt, b_mo, b_st, b_so, b_tick, b_wrap}, pack(1, 0, 0, 0));

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      adj   = ($urandom_range(0, 9) == 0) ? ~adj : adj;
      pause = ($urandom_range(0, 7) == 0);
      sel   = ($urandom_range(0, 15) == 0) ? ~sel : sel;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
